demux3_writeback: RTL and testbench
===================================

Name: demux3_writeback

Overview:
- 1-to-3 write-back distributor for the Simple NN datapath. It is the inverse of the 3-input 14-bit select mux that feeds the neuron datapath.
- Takes a single stream of 14-bit results with a 2-bit destination select and steers each word into one of three one-entry destination buffers (old-value / weight / output paths).
- Each buffer has its own valid/ready handshake. Select code 2'b11 is illegal; such words are dropped, flagged and counted.

Parameters:
- DW, 14, data width of input and all destination buffers.
- CNTW, 8, width of the saturating drop counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input word present.
- in_ready  output  1  input word accepted this cycle when in_valid&in_ready.
- in_data  input  DW  result word.
- in_sel  input  2  destination: 00→d1, 01→d2, 10→d3, 11→illegal.
- d1_valid / d2_valid / d3_valid  output  1 each  destination buffer full.
- d1_ready / d2_ready / d3_ready  input  1 each  consumer takes word when valid&ready.
- d1_data / d2_data / d3_data  output  DW each  buffered word.
- err  output  1  sticky: an illegal select was accepted.
- clr_err  input  1  clears err and drop_cnt.
- drop_cnt  output  CNTW  number of illegal words dropped, saturating.

Behaviour:
- Reset (rst=1 at clk edge): all dN_valid=0, dN_data=0, err=0, drop_cnt=0. Reset mid-transfer discards any buffered words with no output pulse. in_ready is combinational and may be 1 during reset; words presented while rst=1 are ignored.
- Per-destination buffer states:
  - EMPTY → FULL on accept.
  - FULL → EMPTY on drain (dN_valid&dN_ready) with no accept.
  - FULL stays FULL on drain and accept in the same cycle (pass-through refill).
- in_ready, combinational:
  - sel=00/01/10: !dN_valid | dN_ready for the selected N.
  - sel=11: always 1.
- Accept for sel in {00,01,10}: dN_data<=in_data, dN_valid<=1 at the same edge. Latency is 1 cycle, accept edge to dN_valid visible.
- Unselected buffers are never modified by an accept. Drains on other destinations proceed independently in the same cycle.
- Accept with sel=11: data discarded, err<=1, drop_cnt<=drop_cnt+1 saturating at 2^CNTW-1. No dN_valid changes.
- clr_err=1 together with an illegal accept in the same cycle: the clear wins, so err=0 and drop_cnt=0 after the edge.
- dN_data is stable while dN_valid=1 && !dN_ready. Consumers may rely on the hold.
- Throughput: 1 word/cycle while consumers keep ready high.
- in_data and in_sel must be stable while in_valid=1 && !in_ready. This is checked by the bench, not by the RTL.

Optional Feature:
- Macro: DEMUX3_AUTO_SEL_EN.
- Defined:
  - in_sel is ignored. An internal 2-bit round-robin pointer (reset 00) selects the destination, sequence 00→01→10→00, advancing only on an accepted word.
  - in_ready follows the pointer's buffer.
  - err and drop_cnt are tied to 0; the illegal path is unreachable.
- Not defined: the destination comes from in_sel as described above. No pointer logic is generated.

Test Plan:
- Reset then in_valid=1, sel=01, data=14'h1A5, d2_ready=0 → cycle+1: d2_valid=1, d2_data=14'h1A5, d1_valid=d3_valid=0. Next word to sel=01 sees in_ready=0 until d2_ready=1.
- Back-to-back streaming 00,01,10,00 with data 1,2,3,4 and all readies=1 → in_ready held 1, each dN_valid pulses one cycle with the matching data, no stall.
- Full d1 with d1_ready=1 and a simultaneous accept of data 14'h3FFF to sel=00 → d1_valid stays 1, d1_data=14'h3FFF next cycle, old word consumed exactly once.
- Three accepts with sel=11 → in_ready=1 each cycle, err=1, drop_cnt=3, no dN_valid. Then clr_err=1 in the same cycle as a fourth sel=11 accept → err=0, drop_cnt=0.
- 300 illegal accepts with CNTW=8 → drop_cnt saturates at 255.
- rst asserted while all three buffers are full → all valids 0 and data 0 next cycle. With DEMUX3_AUTO_SEL_EN defined, after reset 4 accepts with in_sel=11 land in d1,d2,d3,d1 and err stays 0.

Source files
------------

// File: rtl/demux3_writeback.sv
// demux3_writeback: 1-to-3 write-back distributor; define DEMUX3_AUTO_SEL_EN for round-robin destination select
module demux3_writeback #(
    parameter int DW   = 14,
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    input  logic [1:0]      in_sel,
    output logic            d1_valid,
    output logic            d2_valid,
    output logic            d3_valid,
    input  logic            d1_ready,
    input  logic            d2_ready,
    input  logic            d3_ready,
    output logic [DW-1:0]   d1_data,
    output logic [DW-1:0]   d2_data,
    output logic [DW-1:0]   d3_data,
    output logic            err,
    input  logic            clr_err,
    output logic [CNTW-1:0] drop_cnt
);
    logic [1:0]    sel;
    logic [2:0]    vld;
    logic [2:0]    rdy;
    logic [3:0]    room;
    logic [DW-1:0] dat [3];
    logic          acc;

    assign rdy = {d3_ready, d2_ready, d1_ready};
    assign {d3_valid, d2_valid, d1_valid} = vld;
    assign d1_data = dat[0];
    assign d2_data = dat[1];
    assign d3_data = dat[2];
    // The illegal code 11 always has room so dropped words never stall the stream
    assign room = {1'b1, rdy | ~vld};
    assign in_ready = room[sel];
    assign acc = in_valid & in_ready;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                vld[i] <= 1'b0;
                dat[i] <= '0;
            end else if (acc && sel == 2'(i)) begin
                vld[i] <= 1'b1;
                dat[i] <= in_data;
            end else if (rdy[i]) begin
                vld[i] <= 1'b0;
            end
        end
    end

`ifdef DEMUX3_AUTO_SEL_EN
    logic [1:0] ptr;
    logic       unused_in;

    assign unused_in = ^{in_sel, clr_err};
    assign sel = ptr;
    assign err = 1'b0;
    assign drop_cnt = '0;

    always_ff @(posedge clk) begin
        if (rst)
            ptr <= 2'd0;
        else if (acc)
            ptr <= (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
    end
`else
    assign sel = in_sel;

    always_ff @(posedge clk) begin
        if (rst || clr_err) begin
            err      <= 1'b0;
            drop_cnt <= '0;
        end else if (acc && sel == 2'd3) begin
            err      <= 1'b1;
            drop_cnt <= (drop_cnt == '1) ? drop_cnt : drop_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_demux3_writeback.sv
// tb_demux3_writeback: directed plan plus random traffic against a buffer-level reference model
module tb_demux3_writeback;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [13:0] in_data = '0;
    logic [1:0]  in_sel = '0;
    logic        d1_valid, d2_valid, d3_valid;
    logic        d1_ready = 1'b0, d2_ready = 1'b0, d3_ready = 1'b0;
    logic [13:0] d1_data, d2_data, d3_data;
    logic        err;
    logic        clr_err = 1'b0;
    logic [7:0]  drop_cnt;

    int n_vec = 0;
    int n_err = 0;
    bit chk_on = 1'b0;
    bit stall = 1'b0;

    bit   [2:0]  mv = '0;
    logic [13:0] md [3] = '{default: '0};
    bit          merr = 1'b0;
    int          mcnt = 0;
    int          mptr = 0;

    demux3_writeback dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sel(in_sel),
        .d1_valid(d1_valid), .d2_valid(d2_valid), .d3_valid(d3_valid),
        .d1_ready(d1_ready), .d2_ready(d2_ready), .d3_ready(d3_ready),
        .d1_data(d1_data), .d2_data(d2_data), .d3_data(d3_data),
        .err(err), .clr_err(clr_err), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int dest();
`ifdef DEMUX3_AUTO_SEL_EN
        return mptr;
`else
        return int'(in_sel);
`endif
    endfunction

    function automatic bit exp_ready();
        bit [2:0] r = {d3_ready, d2_ready, d1_ready};
        int n = dest();
        return n == 3 || !mv[n] || r[n];
    endfunction

    // Checks outputs mid-cycle, then advances the model across the coming edge
    task automatic step();
        bit [2:0] r = {d3_ready, d2_ready, d1_ready};
        bit er = exp_ready();
        bit a = in_valid && er;
        int n = dest();
        #4;
        if (chk_on) begin
            chk("in_ready", in_ready, er);
            chk("d1_valid", d1_valid, mv[0]);
            chk("d2_valid", d2_valid, mv[1]);
            chk("d3_valid", d3_valid, mv[2]);
            chk("d1_data", d1_data, md[0]);
            chk("d2_data", d2_data, md[1]);
            chk("d3_data", d3_data, md[2]);
            chk("err", err, merr);
            chk("drop_cnt", drop_cnt, mcnt);
        end
        if (rst) begin
            mv = '0;
            md = '{default: '0};
            merr = 0;
            mcnt = 0;
            mptr = 0;
        end else begin
            for (int k = 0; k < 3; k++)
                if (a && n == k) begin
                    mv[k] = 1;
                    md[k] = in_data;
                end else if (r[k]) mv[k] = 0;
`ifdef DEMUX3_AUTO_SEL_EN
            if (a) mptr = (mptr + 1) % 3;
`else
            if (clr_err) begin
                merr = 0;
                mcnt = 0;
            end else if (a && n == 3) begin
                merr = 1;
                mcnt = (mcnt < 255) ? mcnt + 1 : 255;
            end
`endif
        end
        stall = in_valid && !er && !rst;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [1:0] s, input logic [13:0] d, input bit [2:0] r);
        in_valid = v;
        in_sel = s;
        in_data = d;
        {d3_ready, d2_ready, d1_ready} = r;
        step();
    endtask

    initial begin
        rst = 1;
        step();
        chk_on = 1;
        rst = 0;
        drive(0, 0, 0, 3'b000);
        chk("rst_d1_valid", d1_valid, 0);
`ifndef DEMUX3_AUTO_SEL_EN
        drive(1, 1, 14'h1A5, 3'b000);
        chk("tp1_d2_valid", d2_valid, 1);
        chk("tp1_d2_data", d2_data, 14'h1A5);
        chk("tp1_others", {d1_valid, d3_valid}, 0);
        drive(1, 1, 14'h055, 3'b000);
        chk("tp1_hold", d2_data, 14'h1A5);
        drive(1, 1, 14'h055, 3'b010);
        chk("tp1_refill", d2_data, 14'h055);
        drive(0, 0, 0, 3'b111);
        for (int k = 0; k < 4; k++) begin
            drive(1, 2'(k % 3), 14'(k + 1), 3'b111);
            chk("tp2_data", k % 3 == 0 ? d1_data : k % 3 == 1 ? d2_data : d3_data, k + 1);
        end
        drive(0, 0, 0, 3'b111);
        chk("tp2_idle", {d1_valid, d2_valid, d3_valid}, 0);
        drive(1, 0, 14'h111, 3'b000);
        drive(1, 0, 14'h3FFF, 3'b001);
        chk("tp3_valid", d1_valid, 1);
        chk("tp3_data", d1_data, 14'h3FFF);
        drive(0, 0, 0, 3'b001);
        chk("tp3_drained", d1_valid, 0);
        for (int k = 0; k < 3; k++) drive(1, 3, 14'(k), 3'b000);
        chk("tp4_err", err, 1);
        chk("tp4_cnt", drop_cnt, 3);
        chk("tp4_novalid", {d1_valid, d2_valid, d3_valid}, 0);
        clr_err = 1;
        drive(1, 3, 0, 3'b000);
        clr_err = 0;
        chk("tp4_clr_err", err, 0);
        chk("tp4_clr_cnt", drop_cnt, 0);
        for (int k = 0; k < 300; k++) drive(1, 3, 14'(k), 3'b000);
        chk("tp5_sat", drop_cnt, 255);
        for (int k = 0; k < 3; k++) drive(1, 2'(k), 14'(k + 7), 3'b000);
        chk("tp6_full", {d1_valid, d2_valid, d3_valid}, 3'b111);
        rst = 1;
        drive(0, 0, 0, 3'b000);
        rst = 0;
        chk("tp6_valid", {d1_valid, d2_valid, d3_valid}, 0);
        chk("tp6_data", {d1_data, d2_data, d3_data}, 0);
`else
        for (int k = 0; k < 4; k++) begin
            drive(1, 3, 14'(k + 1), 3'b111);
            chk("auto_data", k % 3 == 0 ? d1_data : k % 3 == 1 ? d2_data : d3_data, k + 1);
            chk("auto_err", err, 0);
        end
`endif
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            clr_err = ($urandom_range(0, 29) == 0);
            {d3_ready, d2_ready, d1_ready} = 3'($urandom);
            if (!stall) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_sel = 2'($urandom);
                in_data = 14'($urandom);
            end
            step();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
